// File: rtl/riscv_pkg.sv
// Shared RV32I encodings: opcodes, ALU control codes, result/immediate selects.
// The execute stage decodes ALUControl and ResultSrc with these same values.
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_t;

   typedef enum logic [2:0] {
      IMM_NONE = 3'b000,
      IMM_I    = 3'b001,
      IMM_S    = 3'b010,
      IMM_B    = 3'b011,
      IMM_J    = 3'b100
   } imm_src_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        alu_src;
      result_src_t result_src;
      imm_src_t    imm_src;
      alu_op_t     alu_op;
   } ctrl_t;

   // sub exists only for R-type; I-type funct3=000 is always addi
   function automatic alu_ctrl_t alu_decode(input logic [2:0] funct3,
                                            input logic       funct7b5,
                                            input logic       is_r);
      alu_ctrl_t res;
      case (funct3)
         3'b000:  res = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  res = ALU_SLT;
         3'b110:  res = ALU_OR;
         3'b111:  res = ALU_AND;
         default: res = ALU_ADD;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two async read ports with writeback bypass,
// one synchronous write port, synchronous active-low clear of every entry.
module register_file (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  a1,
   input  logic [4:0]  a2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);

   logic [31:0] mem [32];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (wa != 5'd0)) begin
         mem[wa] <= wd;
      end
   end

   // Bypass lets decode see the value writeback commits at this same edge
   always_comb begin
      rd1 = '0;
      if (a1 != 5'd0) begin
         if (we && (wa == a1)) rd1 = wd;
         else                  rd1 = mem[a1];
      end
   end

   always_comb begin
      rd2 = '0;
      if (a2 != 5'd0) begin
         if (we && (wa == a2)) rd2 = wd;
         else                  rd2 = mem[a2];
      end
   end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, immediate extend, register file read
// and the ID/EX pipeline register with flush-to-bubble.
module decode_cycle
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] InstrD,
   input  logic [31:0] PCD,
   input  logic [31:0] PCPlus4D,
   input  logic        FlushE,
   input  logic        RegWriteW,
   input  logic [4:0]  RdW,
   input  logic [31:0] ResultW,
   output logic        RegWriteE,
   output logic        MemWriteE,
   output logic        BranchE,
   output logic        JumpE,
   output logic        ALUSrcE,
   output logic [1:0]  ResultSrcE,
   output logic [2:0]  ALUControlE,
   output logic [31:0] RD1E,
   output logic [31:0] RD2E,
   output logic [31:0] ImmExtE,
   output logic [4:0]  Rs1E,
   output logic [4:0]  Rs2E,
   output logic [4:0]  RdE,
   output logic [31:0] PCE,
   output logic [31:0] PCPlus4E
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   ctrl_t       ctrl;
   alu_ctrl_t   alu_ctrl;
   logic [31:0] imm_ext;
   logic [31:0] rd1;
   logic [31:0] rd2;

   assign opcode   = InstrD[6:0];
   assign rd       = InstrD[11:7];
   assign funct3   = InstrD[14:12];
   assign rs1      = InstrD[19:15];
   assign rs2      = InstrD[24:20];
   assign funct7b5 = InstrD[30];

   // Unknown opcodes leave ctrl all-zero, which is exactly a bubble
   always_comb begin
      ctrl = '0;
      case (opcode)
         OP_R: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         OP_I: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.imm_src   = IMM_I;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         OP_LOAD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RES_MEM;
            ctrl.imm_src    = IMM_I;
         end
         OP_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.imm_src   = IMM_S;
         end
         OP_BRANCH: begin
            ctrl.branch  = 1'b1;
            ctrl.imm_src = IMM_B;
            ctrl.alu_op  = ALUOP_SUB;
         end
         OP_JAL: begin
            ctrl.reg_write  = 1'b1;
            ctrl.jump       = 1'b1;
            ctrl.result_src = RES_PC4;
            ctrl.imm_src    = IMM_J;
         end
         default: ctrl = '0;
      endcase
   end

   always_comb begin
      alu_ctrl = ALU_ADD;
      case (ctrl.alu_op)
         ALUOP_SUB:   alu_ctrl = ALU_SUB;
         ALUOP_FUNCT: alu_ctrl = alu_decode(funct3, funct7b5, opcode == OP_R);
         default:     alu_ctrl = ALU_ADD;
      endcase
   end

   always_comb begin
      imm_ext = '0;
      case (ctrl.imm_src)
         IMM_I:   imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
         IMM_S:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMM_B:   imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25],
                             InstrD[11:8], 1'b0};
         IMM_J:   imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20],
                             InstrD[30:21], 1'b0};
         default: imm_ext = '0;
      endcase
   end

   register_file u_register_file (
      .clk (clk),
      .rst (rst),
      .a1  (rs1),
      .a2  (rs2),
      .rd1 (rd1),
      .rd2 (rd2),
      .we  (RegWriteW),
      .wa  (RdW),
      .wd  (ResultW)
   );

   always_ff @(posedge clk) begin
      if (!rst || FlushE) begin
         RegWriteE   <= 1'b0;
         MemWriteE   <= 1'b0;
         BranchE     <= 1'b0;
         JumpE       <= 1'b0;
         ALUSrcE     <= 1'b0;
         ResultSrcE  <= '0;
         ALUControlE <= '0;
         RD1E        <= '0;
         RD2E        <= '0;
         ImmExtE     <= '0;
         Rs1E        <= '0;
         Rs2E        <= '0;
         RdE         <= '0;
         PCE         <= '0;
         PCPlus4E    <= '0;
      end else begin
         RegWriteE   <= ctrl.reg_write;
         MemWriteE   <= ctrl.mem_write;
         BranchE     <= ctrl.branch;
         JumpE       <= ctrl.jump;
         ALUSrcE     <= ctrl.alu_src;
         ResultSrcE  <= ctrl.result_src;
         ALUControlE <= alu_ctrl;
         RD1E        <= rd1;
         RD2E        <= rd2;
         ImmExtE     <= imm_ext;
         Rs1E        <= rs1;
         Rs2E        <= rs2;
         RdE         <= rd;
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
      end
   end

endmodule
